// File: rtl/uart_hex_rx.sv
// -----------------------------------------------------------------------------
// uart_hex_rx
//   Serial front end for the parameter/image loader. Receives UART characters
//   on the board RX pin, decodes ASCII hex digits into 4-bit nibbles and emits
//   each one with a single-cycle done tick. Whitespace (space, TAB, LF, CR) is
//   skipped silently. Badly framed characters and non-hex characters are
//   flagged and dropped.
//
//   Optional feature: define UART_HEX_RX_PARITY_EN for 8E1 framing (a PARITY
//   state between DATA and STOP). Without it the frame is plain 8N1.
//
// Parameters
//   C_CLKFREQ       system clock frequency in Hz
//   C_BAUDRATE      line rate in baud; bit period = C_CLKFREQ / C_BAUDRATE
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   rx_i            asynchronous serial line, idles high
//   dout_o          last decoded nibble, held until the next valid one
//   rx_done_tick_o  one-cycle pulse, dout_o valid in the same cycle
//   frame_err_o     one-cycle pulse on a framing (or parity) error
//   char_err_o      one-cycle pulse on a well-framed non-hex, non-space char
// -----------------------------------------------------------------------------
module uart_hex_rx #(
   parameter int C_CLKFREQ  = 100_000_000,
   parameter int C_BAUDRATE = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [3:0] dout_o,
   output logic       rx_done_tick_o,
   output logic       frame_err_o,
   output logic       char_err_o
);

   localparam int BIT_T  = C_CLKFREQ / C_BAUDRATE;
   localparam int HALF_T = BIT_T / 2;
   localparam int TW     = $clog2(BIT_T) + 1;

   localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_T - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(HALF_T - 1);
   localparam logic [TW-1:0] TIMER_ONE = TW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_HEX_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_DECODE,
      S_BREAK
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [3:0]    dout_q, dout_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;
   logic          cerr_q, cerr_d;
   logic          rx_meta_q, rx_meta_d;
   logic          rx_s_q, rx_s_d;
`ifdef UART_HEX_RX_PARITY_EN
   logic          par_err_q, par_err_d;
`endif

   logic bit_end;
   logic is_dec, is_hex_alpha, is_space;

   assign bit_end = (timer_q == BIT_LAST);

   // Character classes of the byte sitting in the shift register.
   assign is_dec       = (shreg_q >= 8'h30) && (shreg_q <= 8'h39);
   assign is_hex_alpha = ((shreg_q >= 8'h41) && (shreg_q <= 8'h46)) ||
                         ((shreg_q >= 8'h61) && (shreg_q <= 8'h66));
   assign is_space     = (shreg_q == 8'h20) || (shreg_q == 8'h09) ||
                         (shreg_q == 8'h0A) || (shreg_q == 8'h0D);

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      dout_d    = dout_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      cerr_d    = 1'b0;
      rx_meta_d = rx_i;
      rx_s_d    = rx_meta_q;
`ifdef UART_HEX_RX_PARITY_EN
      par_err_d = par_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            timer_d   = '0;
            bit_idx_d = 3'd0;
            if (!rx_s_q) state_d = S_START;
         end

         // Re-check the line at mid start bit; a short low glitch returns to
         // IDLE without producing any output.
         S_START: begin
            if (timer_q == HALF_LAST) begin
               timer_d = '0;
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         // Sampling at BIT_T-1 after the mid-start point lands mid-bit.
         S_DATA: begin
            if (bit_end) begin
               timer_d   = '0;
               shreg_d   = {rx_s_q, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_HEX_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

`ifdef UART_HEX_RX_PARITY_EN
         // Even parity: the XOR over data plus parity bit must be zero.
         S_PARITY: begin
            if (bit_end) begin
               timer_d   = '0;
               par_err_d = ^{shreg_q, rx_s_q};
               state_d   = S_STOP;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
`endif

         S_STOP: begin
            if (bit_end) begin
               timer_d = '0;
               if (!rx_s_q) begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
`ifdef UART_HEX_RX_PARITY_EN
               end else if (par_err_q) begin
                  ferr_d  = 1'b1;
                  state_d = S_IDLE;
`endif
               end else begin
                  state_d = S_DECODE;
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         // Letters a-f / A-F have low nibble 1..6, so +9 maps them to 10..15.
         S_DECODE: begin
            state_d = S_IDLE;
            if (is_dec) begin
               dout_d = shreg_q[3:0];
               done_d = 1'b1;
            end else if (is_hex_alpha) begin
               dout_d = shreg_q[3:0] + 4'd9;
               done_d = 1'b1;
            end else if (!is_space) begin
               cerr_d = 1'b1;
            end
         end

         // A line held low after a bad stop bit is one error, not a stream
         // of zero bytes; wait for the line to return high.
         S_BREAK: begin
            timer_d = '0;
            if (rx_s_q) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its _d input regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bit_idx_q <= 3'd0;
         shreg_q   <= 8'h00;
         dout_q    <= 4'h0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         cerr_q    <= 1'b0;
         // Synchroniser resets to the idle level so reset release never looks
         // like a start bit.
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
`ifdef UART_HEX_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         dout_q    <= dout_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
         cerr_q    <= cerr_d;
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
`ifdef UART_HEX_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   assign dout_o         = dout_q;
   assign rx_done_tick_o = done_q;
   assign frame_err_o    = ferr_q;
   assign char_err_o     = cerr_q;

endmodule

// File: tb/tb_uart_hex_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_hex_rx
//   Self-checking bench for uart_hex_rx at 1 MHz / 100 kBd (BIT_T=10).
//   A reference model classifies each transmitted character into the event it
//   must produce (nibble tick, character error, frame error or nothing) and
//   queues it; a monitor pops the queue on every observed pulse.
// -----------------------------------------------------------------------------
module tb_uart_hex_rx;

   localparam int BIT_T  = 10;
   localparam int HALF_T = 5;
`ifdef UART_HEX_RX_PARITY_EN
   localparam int N_EXTRA = 1;
`else
   localparam int N_EXTRA = 0;
`endif
   // Pin edge -> rx_s (2) + start/data/stop timing + decode/output (2).
   localparam int LATENCY = 2 + HALF_T + (9 + N_EXTRA) * BIT_T + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [3:0] dout;
   logic       done, ferr, cerr;

   uart_hex_rx #(
      .C_CLKFREQ (1_000_000),
      .C_BAUDRATE(100_000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_i          (rx),
      .dout_o        (dout),
      .rx_done_tick_o(done),
      .frame_err_o   (ferr),
      .char_err_o    (cerr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef enum int {EV_TICK = 0, EV_CERR = 1, EV_FERR = 2} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       nib;
   } ev_t;

   ev_t exp_q[$];
   int  model_dout   = 0;
   int  start_cyc    = 0;
   int  last_tick_cyc = 0;

   function automatic void predict(input logic [7:0] b, input bit stop_ok);
      int  v = int'(b);
      ev_t e;
      e.nib = 0;
      if (!stop_ok) begin
         e.kind = EV_FERR; exp_q.push_back(e);
      end else if (v >= 48 && v <= 57) begin
         e.kind = EV_TICK; e.nib = v - 48; exp_q.push_back(e); model_dout = e.nib;
      end else if (v >= 65 && v <= 70) begin
         e.kind = EV_TICK; e.nib = v - 55; exp_q.push_back(e); model_dout = e.nib;
      end else if (v >= 97 && v <= 102) begin
         e.kind = EV_TICK; e.nib = v - 87; exp_q.push_back(e); model_dout = e.nib;
      end else if (!(v == 32 || v == 9 || v == 10 || v == 13)) begin
         e.kind = EV_CERR; exp_q.push_back(e);
      end
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      ev_t e;
      int  obs_kind;
      if (!rst && (done || ferr || cerr)) begin
         check("one_flag", int'(done) + int'(ferr) + int'(cerr), 1);
         obs_kind = done ? EV_TICK : (cerr ? EV_CERR : EV_FERR);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {done, ferr, cerr}, 0);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", obs_kind, e.kind);
            if (done) begin
               check("tick_dout", dout, e.nib);
               last_tick_cyc = cyc;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      start_cyc = cyc;
      drive_bit(1'b0, BIT_T);
      for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_T);
`ifdef UART_HEX_RX_PARITY_EN
      drive_bit(^b, BIT_T);
`endif
      drive_bit(stop_bit, BIT_T);
   endtask

   task automatic send_char(input logic [7:0] b);
      predict(b, 1'b1);
      send_frame(b, 1'b1);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 4 * BIT_T && exp_q.size() > 0; i++) @(negedge clk);
      check({tag, "_pending"}, exp_q.size(), 0);
      check({tag, "_dout"}, dout, model_dout);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_dout"}, dout, 0);
      check({tag, "_flags"}, {done, ferr, cerr}, 0);
   endtask

   // ---------------- stimulus ----------------
   string hex_chars = "0123456789abcdefABCDEF";

   initial begin : stim
      logic [7:0] b;
      int         cat;

      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      drive_bit(1'b1, 2 * BIT_T);
      check_outputs_zero("post_reset");

      // 'A' with latency measurement
      send_char(8'h41);
      drive_bit(1'b1, BIT_T);
      drain("char_A");
      check("A_latency", last_tick_cyc - start_cyc, LATENCY);

      // "3f\r\n" back-to-back
      send_char(8'h33);
      send_char(8'h66);
      send_char(8'h0D);
      send_char(8'h0A);
      drive_bit(1'b1, 2 * BIT_T);
      drain("str_3f_crlf");

      // '7' then 'G' -> char error, dout stays 7
      send_char(8'h37);
      send_char(8'h47);
      drive_bit(1'b1, 2 * BIT_T);
      drain("char_G");

      // 0x35 with bad stop, line held low, then '9'
      predict(8'h35, 1'b0);
      send_frame(8'h35, 1'b0);
      drive_bit(1'b0, 40);
      drive_bit(1'b1, 2 * BIT_T);
      drain("break");
      send_char(8'h39);
      drive_bit(1'b1, BIT_T);
      drain("after_break");

      // 3-cycle glitch, then 'c'
      drive_bit(1'b0, 3);
      drive_bit(1'b1, 2 * BIT_T);
      drain("glitch");
      send_char(8'h63);
      drive_bit(1'b1, BIT_T);
      drain("after_glitch");

      // reset during 4th data bit of '5', then '2'
      b = 8'h35;
      drive_bit(1'b0, BIT_T);
      for (int i = 0; i < 3; i++) drive_bit(b[i], BIT_T);
      drive_bit(b[3], 5);
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("mid_reset");
      rst = 1'b0;
      exp_q.delete();
      model_dout = 0;
      drive_bit(1'b1, 3 * BIT_T);
      drain("after_mid_reset");
      send_char(8'h32);
      drive_bit(1'b1, BIT_T);
      drain("char_2");

      // randomized traffic
      for (int n = 0; n < 30; n++) begin
         cat = $urandom_range(0, 3);
         case (cat)
            0: b = hex_chars[$urandom_range(0, hex_chars.len() - 1)];
            1: case ($urandom_range(0, 3))
                  0: b = 8'h20;
                  1: b = 8'h09;
                  2: b = 8'h0A;
                  default: b = 8'h0D;
               endcase
            default: b = 8'($urandom_range(0, 255));
         endcase
         if (cat == 3) begin
            predict(b, 1'b0);
            send_frame(b, 1'b0);
            drive_bit(1'b0, $urandom_range(0, 30));
            drive_bit(1'b1, 1);
         end else begin
            send_char(b);
         end
         drive_bit(1'b1, $urandom_range(0, BIT_T));
         drain("random");
      end

      drive_bit(1'b1, 2 * BIT_T);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_hex_rx.md
Name: uart_hex_rx

Overview:
- Serial front end for the parameter/image loader.
- Receives 8N1 UART characters on the board RX pin and decodes ASCII hex digits into 4-bit nibbles.
- Emits each valid nibble with a one-cycle done tick. This is the nibble/tick stream the loader packs into the coef, bias and img buffers.
- Whitespace is skipped. Malformed frames and non-hex characters are flagged and dropped.

Parameters:
- C_CLKFREQ, 100_000_000, system clock frequency in Hz.
- C_BAUDRATE, 115_200, line rate in baud. Bit period is BIT_T = C_CLKFREQ / C_BAUDRATE (integer division, 868 at defaults). Half period is HALF_T = BIT_T / 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_i  input  1  asynchronous serial line, idles high.
- dout_o  output  4  last decoded nibble; holds until the next valid nibble.
- rx_done_tick_o  output  1  one-cycle pulse; dout_o is valid in the same cycle.
- frame_err_o  output  1  one-cycle pulse on framing (or parity) error.
- char_err_o  output  1  one-cycle pulse on a well-framed, non-hex, non-whitespace character.

Behaviour:
- Input synchroniser:
  - Two flops on rx_i, both reset to 1, so there is no false start bit out of reset.
  - All FSM decisions use the second flop (rx_s).
- Reset values: dout_o=0, rx_done_tick_o=0, frame_err_o=0, char_err_o=0, FSM=IDLE, timer=0, bit index=0, shift register=0.
- FSM states: IDLE, START, DATA, STOP, DECODE, BREAK.
  - IDLE: timer held at 0. rx_s==0 -> START.
  - START: timer counts. At timer==HALF_T-1: if rx_s==0 -> DATA (timer=0, bit index=0); else glitch -> IDLE, no output.
  - DATA: at timer==BIT_T-1, sample rx_s and shift in LSB-first, then clear timer. After the 8th sample -> STOP.
  - STOP: at timer==BIT_T-1, sample rx_s. If 1 -> DECODE. If 0 -> pulse frame_err_o and go to BREAK; the byte is discarded.
  - DECODE: single cycle, always -> IDLE.
    - 0x30-0x39 -> nibble 0-9.
    - 0x41-0x46 and 0x61-0x66 -> nibble 10-15.
    - For a hex character: register dout_o and pulse rx_done_tick_o in the cycle after DECODE (registered outputs).
    - 0x20, 0x09, 0x0A, 0x0D are silently ignored: no pulse of any kind.
    - Any other byte -> pulse char_err_o; dout_o unchanged.
  - BREAK: wait until rx_s==1, then -> IDLE. A line held low never produces repeated bytes or errors.
- Latency: rx_done_tick_o rises 2 cycles after the stop-bit sample edge. Overall that is about HALF_T + 9*BIT_T + 2 cycles after the falling start edge reaches rx_s.
- Flags are mutually exclusive per character: at most one of rx_done_tick_o, frame_err_o, char_err_o pulses per received frame.
- Back-to-back frames: a start bit immediately after the stop bit's mid-sample is accepted. IDLE is re-entered before the next falling edge can arrive.
- Reset mid-operation: rst has priority in any state.
  - Returns the FSM to IDLE and clears all outputs, the timer and the partial byte in the same cycle.
  - A partially received frame produces no tick and no error.
- Timer width: clog2(BIT_T)+1 bits; it never wraps inside a bit period.

Optional Feature:
- Macro: UART_HEX_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP.
  - It samples at timer==BIT_T-1 and checks even parity over the 8 data bits plus the parity bit.
  - On mismatch: pulse frame_err_o, discard the byte, go to BREAK if rx_s==0 at the stop sample, else IDLE after the stop period.
  - Latency grows by BIT_T.
- Not defined: 8N1 exactly as above; no PARITY state or logic.

Test Plan (C_CLKFREQ=1_000_000, C_BAUDRATE=100_000, so BIT_T=10, HALF_T=5):
- Send 0x41 ('A') 8N1 -> one rx_done_tick_o with dout_o=4'hA, about 97 cycles after the start edge; no error pulses.
- Send "3f\r\n" back-to-back -> exactly two ticks, dout_o=4'h3 then 4'hF; CR and LF produce no pulses.
- After "7", send 0x47 ('G') -> char_err_o pulses once, no tick, dout_o stays 4'h7.
- Send 0x35 with the stop bit driven 0, then hold the line low for 40 cycles, then idle -> one frame_err_o pulse, no tick, no further activity until high; then send "9" -> tick with 4'h9.
- Drive a 3-cycle low glitch on the idle line -> no pulses; FSM back in IDLE; the next byte "c" yields a tick with 4'hC.
- Assert rst for 1 cycle during the 4th data bit of "5", then send "2" -> all outputs 0 after reset, no tick for "5", one tick with 4'h2.
